mem1_dm_access: RTL
===================

# mem1_dm_access

Second memory-access stage of the CUES execution pipeline. It consumes the registered Mem0/Mem1 bundle and performs the data-memory load or store on a local synchronous word-organised RAM. It produces the writeback/route bundle one cycle later, with load data replacing the ALU result. It also detects misaligned accesses and keeps saturating load/store counters for debug.

## Interface
Parameters:
- AW, 12, word-address width; RAM depth is 2^AW 32-bit words; byte address bits [AW+1:0] of dm_addr are used.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- opr0_i  in  32  ALU result / passthrough operand
- opr1_i  in  32  store data
- dm_addr_i  in  14  byte address
- mem_wen_i  in  1  0 = write (store), 1 = read (load)
- dm_dopc_i  in  3  [0]: 1 = no memory op; [2:1]: 00 word, 01 halfword signed, 10 byte unsigned, 11 byte signed
- pe_out_i, pe_num_i[2:0], f_mem_w_i, next_lr_i, next_node_i[15:0], gen_i[11:0], next_uni_opr_i  in  —  routing sideband, passed through
- result_o  out  32  load data (extended) for loads, else opr0 delayed
- pe_out_o, pe_num_o, f_mem_w_o, next_lr_o, next_node_o, gen_o, next_uni_opr_o  out  —  sideband delayed one cycle
- misalign_o  out  1  pulse: the access issued last cycle was misaligned and suppressed
- err_sticky_o  out  1  set by any misalign, cleared only by reset
- ld_cnt_o  out  16  saturating count of performed loads
- st_cnt_o  out  16  saturating count of performed stores

## Operation
- Access valid when dm_dopc_i[0]==0. Store when valid and mem_wen_i==0; load when valid and mem_wen_i==1.
- Word index = dm_addr_i[AW+1:2]; lane = dm_addr_i[1:0]; little-endian (lane 0 = bits 7:0).
- Alignment: word requires lane==0; halfword requires lane[0]==0; byte always aligned. Misaligned access: no RAM write, no counter increment, result_o = opr0 delayed, misalign_o=1 next cycle, err_sticky_o set.
- Store byte enables: word 4'b1111; halfword 4'b0011 << lane; byte 4'b0001 << lane. Store data lane-replicated from opr1_i (byte: {4{opr1[7:0]}}, half: {2{opr1[15:0]}}). Sub-word stores write only enabled lanes; no read-modify-write cycle.
- Load: RAM read synchronous on the issuing edge. Stage registers hold lane and size. Output extraction is combinational from the registered read word: halfword sign-extend, byte 10 zero-extend, byte 11 sign-extend, word as-is.
- Non-memory op or store: result_o = opr0 delayed.
- Counters saturate at 16'hFFFF; no wrap.
- RAM contents are not reset. Reads of never-written words are X in simulation; the bench must not rely on them.

## Timing
- Latency 1 cycle, input to every output, throughput one op per cycle, no stall or handshake.
- Store at edge N is visible to a load issued at edge N+1 (the array is written at N, read at N+1); no forwarding required. Only one op per cycle, so no same-cycle read/write conflict exists.
- Reset (async assert, sync release by clock): all outputs 0, counters 0, err_sticky_o 0, stage registers 0 (decoded as non-memory op, result 0). Reset mid-store: the write at that edge may be lost; any write completed before reset is retained.
- misalign_o high exactly one cycle per offending op; back-to-back misaligned ops keep it high.

## Test plan
- Word store 0xDEADBEEF @0x0010, then word load @0x0010 -> result_o=0xDEADBEEF one cycle after load; st_cnt_o=1, ld_cnt_o=1.
- Byte store 0x5A @0x0013 over word 0x11223344, then word load @0x0010 -> 0x5A223344; byte signed load @0x0013 -> 0x0000005A; byte-signed load of 0x80 lane -> 0xFFFFFF80.
- Halfword store 0x8001 @0x0022, halfword load @0x0022 -> 0xFFFF8001; halfword load @0x0021 -> misalign_o=1, result_o=opr0, RAM unchanged, err_sticky_o=1 until reset.
- dopc[0]=1 with mem_wen=0, opr0=0x12345678 -> no write (subsequent load shows old data), result_o=0x12345678, counters unchanged; sideband next_node=0xBEEF, gen=0xABC appear unchanged one cycle later.
- Force ld_cnt to 0xFFFE via 2 more loads then 1 extra -> holds 0xFFFF; assert rst low mid-stream -> all outputs 0 immediately, counters 0, earlier stored words still readable after release.

Source files
------------

// File: rtl/mem1_dm_access.sv
// Second memory-access stage: data-memory load/store on a local word RAM,
// one-cycle registered writeback/route bundle, misalignment detection and debug counters.
module mem1_dm_access #(
  parameter int AW = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] opr0_i,
  input  logic [31:0] opr1_i,
  input  logic [13:0] dm_addr_i,
  input  logic        mem_wen_i,
  input  logic [2:0]  dm_dopc_i,
  input  logic        pe_out_i,
  input  logic [2:0]  pe_num_i,
  input  logic        f_mem_w_i,
  input  logic        next_lr_i,
  input  logic [15:0] next_node_i,
  input  logic [11:0] gen_i,
  input  logic        next_uni_opr_i,
  output logic [31:0] result_o,
  output logic        pe_out_o,
  output logic [2:0]  pe_num_o,
  output logic        f_mem_w_o,
  output logic        next_lr_o,
  output logic [15:0] next_node_o,
  output logic [11:0] gen_o,
  output logic        next_uni_opr_o,
  output logic        misalign_o,
  output logic        err_sticky_o,
  output logic [15:0] ld_cnt_o,
  output logic [15:0] st_cnt_o
);

  // No handshake: one op is accepted every cycle, there is no valid/ready pair and no stall.
  logic [31:0]   ram [0:(1<<AW)-1];
  logic [31:0]   rd_word;
  logic [AW-1:0] widx;
  logic [1:0]    size;
  logic [1:0]    lane;
  logic          valid;
  logic          aligned;
  logic          do_store;
  logic          do_load;
  logic [3:0]    be;
  logic [31:0]   wdata;

  logic          load_q;
  logic [1:0]    size_q;
  logic [1:0]    lane_q;
  logic [31:0]   opr0_q;
  logic [31:0]   ld_ext;
  logic [15:0]   half_v;
  logic [7:0]    byte_v;

  assign widx  = dm_addr_i[AW+1:2];
  assign lane  = dm_addr_i[1:0];
  assign size  = dm_dopc_i[2:1];
  assign valid = ~dm_dopc_i[0];

  always_comb begin
    aligned = 1'b1;
    be      = 4'b0000;
    wdata   = opr1_i;
    case (size)
      2'b00: begin
        aligned = (lane == 2'b00);
        be      = 4'b1111;
        wdata   = opr1_i;
      end
      2'b01: begin
        aligned = ~lane[0];
        be      = 4'b0011 << lane;
        wdata   = {2{opr1_i[15:0]}};
      end
      default: begin
        aligned = 1'b1;
        be      = 4'b0001 << lane;
        wdata   = {4{opr1_i[7:0]}};
      end
    endcase
  end

  assign do_store = valid & aligned & ~mem_wen_i;
  assign do_load  = valid & aligned & mem_wen_i;

  // RAM is never reset; a store coinciding with reset is simply dropped.
  always_ff @(posedge clk) begin
    if (rst && do_store) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) ram[widx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (do_load) rd_word <= ram[widx];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_q         <= 1'b0;
      size_q         <= 2'b00;
      lane_q         <= 2'b00;
      opr0_q         <= 32'h0;
      pe_out_o       <= 1'b0;
      pe_num_o       <= 3'b000;
      f_mem_w_o      <= 1'b0;
      next_lr_o      <= 1'b0;
      next_node_o    <= 16'h0;
      gen_o          <= 12'h0;
      next_uni_opr_o <= 1'b0;
      misalign_o     <= 1'b0;
      err_sticky_o   <= 1'b0;
      ld_cnt_o       <= 16'h0;
      st_cnt_o       <= 16'h0;
    end else begin
      load_q         <= do_load;
      size_q         <= size;
      lane_q         <= lane;
      opr0_q         <= opr0_i;
      pe_out_o       <= pe_out_i;
      pe_num_o       <= pe_num_i;
      f_mem_w_o      <= f_mem_w_i;
      next_lr_o      <= next_lr_i;
      next_node_o    <= next_node_i;
      gen_o          <= gen_i;
      next_uni_opr_o <= next_uni_opr_i;
      misalign_o     <= valid & ~aligned;
      if (valid && !aligned) err_sticky_o <= 1'b1;
      if (do_load && ld_cnt_o != 16'hFFFF) ld_cnt_o <= ld_cnt_o + 16'd1;
      if (do_store && st_cnt_o != 16'hFFFF) st_cnt_o <= st_cnt_o + 16'd1;
    end
  end

  always_comb begin
    half_v = lane_q[1] ? rd_word[31:16] : rd_word[15:0];
    byte_v = rd_word[{lane_q, 3'b000} +: 8];
    case (size_q)
      2'b00:   ld_ext = rd_word;
      2'b01:   ld_ext = {{16{half_v[15]}}, half_v};
      2'b10:   ld_ext = {24'h0, byte_v};
      default: ld_ext = {{24{byte_v[7]}}, byte_v};
    endcase
  end

  assign result_o = load_q ? ld_ext : opr0_q;

endmodule
